// File: rtl/ltssm_seq_arbiter.sv
// ltssm_seq_arbiter
//   Top-level LTSSM sequencer for the PCIe PHY logical layer. Steps the detect,
//   polling and config substate blocks one at a time, collects their results,
//   retries on error or timeout and parks in FAIL once the retry budget is used
//   up. Also arbitrates the three substate TS ordered-set AXI-Stream sources onto
//   the single PHY TX stream, never cutting a packet in half.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   link_en_i               start/hold link training; low returns to IDLE
//   link_up_o, link_fail_o  high while in L0 / FAIL (registered)
//   ltssm_state_o           IDLE=0 DETECT=1 POLLING=2 CONFIG=3 L0=4 RESTART=5 FAIL=6
//   retry_cnt_o             errors since the last IDLE/L0 entry
//   sub_en_o                [0]=detect [1]=polling [2]=config enable (registered)
//   sub_success_i/_error_i  per-substate result pulses, same bit order
//   s_axis_*                three packed source streams, source g at slice g
//   m_axis_*                muxed PHY TX stream

module ltssm_seq_arbiter #(
  parameter int          DATA_WIDTH     = 32,
  parameter int          KEEP_WIDTH     = DATA_WIDTH / 8,
  // width of the PHY sideband user field carried with each beat
  parameter int          USER_WIDTH     = 4,
  parameter int          RETRY_MAX      = 3,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'h015B8D80,
  localparam int         RCW            = $clog2(RETRY_MAX + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    link_en_i,
  output logic                    link_up_o,
  output logic                    link_fail_o,
  output logic [2:0]              ltssm_state_o,
  output logic [RCW-1:0]          retry_cnt_o,
  output logic [2:0]              sub_en_o,
  input  logic [2:0]              sub_success_i,
  input  logic [2:0]              sub_error_i,
  input  logic [3*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [3*KEEP_WIDTH-1:0] s_axis_tkeep_i,
  input  logic [2:0]              s_axis_tvalid_i,
  input  logic [2:0]              s_axis_tlast_i,
  input  logic [3*USER_WIDTH-1:0] s_axis_tuser_i,
  output logic [2:0]              s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep_o,
  output logic                    m_axis_tvalid_o,
  output logic                    m_axis_tlast_o,
  output logic [USER_WIDTH-1:0]   m_axis_tuser_o,
  input  logic                    m_axis_tready_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DETECT  = 3'd1,
    ST_POLLING = 3'd2,
    ST_CONFIG  = 3'd3,
    ST_L0      = 3'd4,
    ST_RESTART = 3'd5,
    ST_FAIL    = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [RCW-1:0]   retry_cnt_q, retry_cnt_d;
  logic [31:0]      timer_q, timer_d;
  logic [2:0]       sub_en_q, sub_en_d;
  logic             link_up_q, link_up_d;
  logic             link_fail_q, link_fail_d;
  logic             lock_q, lock_d;
  logic [1:0]       grant_q, grant_d;

  logic [2:0]       cur_mask;
  logic             cur_success;
  logic             err_event;
  logic             owner_vld;
  logic [1:0]       owner_idx;
  logic             grant_vld;
  logic [1:0]       grant_idx;

  // One-hot substate mask of a state; zero outside DETECT/POLLING/CONFIG.
  function automatic logic [2:0] sub_mask(input state_e s);
    case (s)
      ST_DETECT:  sub_mask = 3'b001;
      ST_POLLING: sub_mask = 3'b010;
      ST_CONFIG:  sub_mask = 3'b100;
      default:    sub_mask = 3'b000;
    endcase
  endfunction

  // Masking with the current substate makes results from the other blocks inert.
  assign cur_mask    = sub_mask(state_q);
  assign cur_success = |(sub_success_i & cur_mask);
  assign err_event   = (|(sub_error_i & cur_mask)) || (timer_q == TIMEOUT_CYCLES - 32'd1);

  // Next-state logic. Error outranks success, link_en_i low outranks both.
  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (link_en_i) state_d = ST_DETECT;
      end
      ST_DETECT, ST_POLLING, ST_CONFIG: begin
        if (!link_en_i) begin
          state_d = ST_IDLE;
        end else if (err_event) begin
          if (retry_cnt_q == RCW'(RETRY_MAX)) begin
            state_d = ST_FAIL;
          end else begin
            retry_cnt_d = retry_cnt_q + RCW'(1);
            state_d     = ST_RESTART;
          end
        end else if (cur_success) begin
          case (state_q)
            ST_DETECT:  state_d = ST_POLLING;
            ST_POLLING: state_d = ST_CONFIG;
            default:    state_d = ST_L0;
          endcase
        end
      end
      ST_RESTART: state_d = link_en_i ? ST_DETECT : ST_IDLE;
      ST_L0, ST_FAIL: begin
        if (!link_en_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // The retry budget restarts whenever training starts over or succeeds.
    if (state_d == ST_IDLE || state_d == ST_L0) retry_cnt_d = '0;

    // Timer restarts on every state change so each substate gets a full budget.
    if (state_d != state_q || sub_mask(state_q) == 3'b000) timer_d = '0;
    else                                                  timer_d = timer_q + 32'd1;

    // Outputs decoded from the next state so they line up with ltssm_state_o.
    sub_en_d    = sub_mask(state_d);
    link_up_d   = (state_d == ST_L0);
    link_fail_d = (state_d == ST_FAIL);
  end

  // Owner follows the active substate; an open packet keeps its source granted.
  always_comb begin
    owner_vld = (cur_mask != 3'b000);
    case (state_q)
      ST_POLLING: owner_idx = 2'd1;
      ST_CONFIG:  owner_idx = 2'd2;
      default:    owner_idx = 2'd0;
    endcase
    grant_vld = lock_q || owner_vld;
    grant_idx = lock_q ? grant_q : owner_idx;
  end

  // Zero-latency stream mux plus lock tracking on accepted beats.
  always_comb begin
    m_axis_tdata_o  = '0;
    m_axis_tkeep_o  = '0;
    m_axis_tvalid_o = 1'b0;
    m_axis_tlast_o  = 1'b0;
    m_axis_tuser_o  = '0;
    s_axis_tready_o = 3'b000;
    for (int g = 0; g < 3; g++) begin
      if (grant_vld && grant_idx == 2'(g)) begin
        m_axis_tdata_o     = s_axis_tdata_i[g*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tkeep_o     = s_axis_tkeep_i[g*KEEP_WIDTH +: KEEP_WIDTH];
        m_axis_tvalid_o    = s_axis_tvalid_i[g];
        m_axis_tlast_o     = s_axis_tlast_i[g];
        m_axis_tuser_o     = s_axis_tuser_i[g*USER_WIDTH +: USER_WIDTH];
        s_axis_tready_o[g] = m_axis_tready_i;
      end
    end
    lock_d  = lock_q;
    grant_d = grant_q;
    if (m_axis_tvalid_o && m_axis_tready_i) begin
      lock_d  = !m_axis_tlast_o;
      grant_d = grant_idx;
    end
  end

  // Single register stage for the sequencer, its outputs and the arbiter lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      retry_cnt_q <= '0;
      timer_q     <= '0;
      sub_en_q    <= 3'b000;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
      lock_q      <= 1'b0;
      grant_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      sub_en_q    <= sub_en_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
      lock_q      <= lock_d;
      grant_q     <= grant_d;
    end
  end

  assign ltssm_state_o = state_q;
  assign retry_cnt_o   = retry_cnt_q;
  assign sub_en_o      = sub_en_q;
  assign link_up_o     = link_up_q;
  assign link_fail_o   = link_fail_q;

endmodule

// File: tb/tb_ltssm_seq_arbiter.sv
// tb_ltssm_seq_arbiter
//   Directed bench for ltssm_seq_arbiter. The main instance uses the default
//   timeout; a second instance with a 16-cycle timeout exercises the forced
//   error path. Expected values are hand-derived constants.

module tb_ltssm_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        link_en;
  logic [2:0]  succ, err;
  logic [95:0] s_tdata;
  logic [11:0] s_tkeep;
  logic [2:0]  s_tvalid, s_tlast;
  logic [11:0] s_tuser;
  logic        m_ready;

  logic        link_up, link_fail;
  logic [2:0]  state;
  logic [1:0]  retry;
  logic [2:0]  sub_en;
  logic [2:0]  s_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast;
  logic [3:0]  m_tuser;

  logic        to_link_en;
  logic [2:0]  zero3;
  logic        to_link_up, to_link_fail;
  logic [2:0]  to_state;
  logic [1:0]  to_retry;
  logic [2:0]  to_sub_en;
  logic [2:0]  to_s_tready;
  logic [31:0] to_m_tdata;
  logic [3:0]  to_m_tkeep;
  logic        to_m_tvalid, to_m_tlast;
  logic [3:0]  to_m_tuser;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ltssm_seq_arbiter dut (
    .clk_i(clk), .rst_i(rst), .link_en_i(link_en),
    .link_up_o(link_up), .link_fail_o(link_fail), .ltssm_state_o(state),
    .retry_cnt_o(retry), .sub_en_o(sub_en),
    .sub_success_i(succ), .sub_error_i(err),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tuser_i(s_tuser), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tkeep_o(m_tkeep), .m_axis_tvalid_o(m_tvalid),
    .m_axis_tlast_o(m_tlast), .m_axis_tuser_o(m_tuser), .m_axis_tready_i(m_ready)
  );

  ltssm_seq_arbiter #(.TIMEOUT_CYCLES(32'd16)) dut_to (
    .clk_i(clk), .rst_i(rst), .link_en_i(to_link_en),
    .link_up_o(to_link_up), .link_fail_o(to_link_fail), .ltssm_state_o(to_state),
    .retry_cnt_o(to_retry), .sub_en_o(to_sub_en),
    .sub_success_i(zero3), .sub_error_i(zero3),
    .s_axis_tdata_i(s_tdata), .s_axis_tkeep_i(s_tkeep), .s_axis_tvalid_i(s_tvalid),
    .s_axis_tlast_i(s_tlast), .s_axis_tuser_i(s_tuser), .s_axis_tready_o(to_s_tready),
    .m_axis_tdata_o(to_m_tdata), .m_axis_tkeep_o(to_m_tkeep), .m_axis_tvalid_o(to_m_tvalid),
    .m_axis_tlast_o(to_m_tlast), .m_axis_tuser_o(to_m_tuser), .m_axis_tready_i(m_ready)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the sequencer inputs for one cycle.
  task automatic applyStimulus(input logic le, input logic [2:0] s, input logic [2:0] e);
    link_en = le;
    succ    = s;
    err     = e;
    tick();
  endtask

  task automatic checkSeq(input string tag, input logic [2:0] st, input logic [2:0] en,
                          input logic [1:0] rc);
    checkOutput({tag, ".state"}, 32'(state), 32'(st));
    checkOutput({tag, ".sub_en"}, 32'(sub_en), 32'(en));
    checkOutput({tag, ".retry"}, 32'(retry), 32'(rc));
  endtask

  // One stream cycle: polling source drives d1, the mux result is checked, then clock.
  task automatic beatCycle(input string tag, input logic [31:0] d1, input logic v1,
                           input logic l1, input logic rdy, input logic [2:0] sc,
                           input logic [31:0] exp_data, input logic [2:0] exp_ready,
                           input logic exp_last, input logic [3:0] exp_user);
    s_tdata[63:32] = d1;
    s_tvalid[1]    = v1;
    s_tlast[1]     = l1;
    m_ready        = rdy;
    succ           = sc;
    err            = 3'b000;
    #1;
    checkOutput({tag, ".tvalid"}, 32'(m_tvalid), 32'd1);
    checkOutput({tag, ".tdata"}, m_tdata, exp_data);
    checkOutput({tag, ".tready"}, 32'(s_tready), 32'(exp_ready));
    checkOutput({tag, ".tlast"}, 32'(m_tlast), 32'(exp_last));
    checkOutput({tag, ".tuser"}, 32'(m_tuser), 32'(exp_user));
    tick();
    succ = 3'b000;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; link_en = 1'b0; succ = '0; err = '0;
    s_tdata = '0; s_tkeep = {4'h7, 4'hF, 4'h1}; s_tvalid = '0; s_tlast = '0;
    s_tuser = {4'h2, 4'h1, 4'h0}; m_ready = 1'b1;
    to_link_en = 1'b0; zero3 = 3'b000;

    // Reset values
    tick(); tick();
    checkSeq("reset", 3'd0, 3'b000, 2'd0);
    checkOutput("reset.link_up", 32'(link_up), 32'd0);
    checkOutput("reset.link_fail", 32'(link_fail), 32'd0);
    checkOutput("reset.tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("reset.tready", 32'(s_tready), 32'd0);
    rst = 1'b0;

    // Happy path, with stray results from other substates ignored
    applyStimulus(1, 3'b000, 3'b000);
    checkSeq("happy.detect", 3'd1, 3'b001, 2'd0);
    repeat (3) applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b110, 3'b010);
    checkSeq("happy.ignore", 3'd1, 3'b001, 2'd0);
    applyStimulus(1, 3'b001, 3'b000);
    checkSeq("happy.polling", 3'd2, 3'b010, 2'd0);
    repeat (5) applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b010, 3'b000);
    checkSeq("happy.config", 3'd3, 3'b100, 2'd0);
    applyStimulus(1, 3'b100, 3'b000);
    checkSeq("happy.l0", 3'd4, 3'b000, 2'd0);
    checkOutput("happy.link_up", 32'(link_up), 32'd1);
    applyStimulus(1, 3'b000, 3'b000);
    checkOutput("happy.hold_l0", 32'(state), 32'd4);

    // Retry path into FAIL
    applyStimulus(0, 3'b000, 3'b000);
    checkSeq("retry.idle", 3'd0, 3'b000, 2'd0);
    checkOutput("retry.link_up", 32'(link_up), 32'd0);
    applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b001, 3'b000);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 3'b000, 3'b010);
      checkSeq("retry.restart", 3'd5, 3'b000, 2'(k));
      applyStimulus(1, 3'b000, 3'b000);
      checkSeq("retry.redetect", 3'd1, 3'b001, 2'(k));
      applyStimulus(1, 3'b001, 3'b000);
    end
    applyStimulus(1, 3'b000, 3'b010);
    checkSeq("retry.fail", 3'd6, 3'b000, 2'd3);
    checkOutput("retry.link_fail", 32'(link_fail), 32'd1);
    applyStimulus(1, 3'b000, 3'b000);
    checkOutput("retry.hold_fail", 32'(state), 32'd6);
    applyStimulus(0, 3'b000, 3'b000);
    checkSeq("retry.back_idle", 3'd0, 3'b000, 2'd0);
    checkOutput("retry.fail_clear", 32'(link_fail), 32'd0);

    // Priority: error beats success, link_en low beats everything
    applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b001, 3'b000);
    applyStimulus(1, 3'b010, 3'b000);
    applyStimulus(1, 3'b100, 3'b100);
    checkSeq("prio.err_wins", 3'd5, 3'b000, 2'd1);
    applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b001, 3'b000);
    applyStimulus(1, 3'b010, 3'b000);
    applyStimulus(0, 3'b100, 3'b000);
    checkSeq("prio.en_low", 3'd0, 3'b000, 2'd0);
    applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b000, 3'b001);
    applyStimulus(0, 3'b000, 3'b000);
    checkOutput("prio.restart_idle", 32'(state), 32'd0);

    // Packet lock across the POLLING->CONFIG change
    applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b000, 3'b001);
    applyStimulus(1, 3'b000, 3'b000);
    applyStimulus(1, 3'b001, 3'b000);
    checkSeq("lock.polling", 3'd2, 3'b010, 2'd1);
    s_tdata[95:64] = 32'hC000_0001;
    s_tvalid[2]    = 1'b1;
    s_tlast[2]     = 1'b1;
    beatCycle("lock.b1", 32'hA1, 1, 0, 1, 3'b000, 32'hA1, 3'b010, 0, 4'h1);
    beatCycle("lock.b2stall", 32'hA2, 1, 0, 0, 3'b000, 32'hA2, 3'b000, 0, 4'h1);
    beatCycle("lock.b2", 32'hA2, 1, 0, 1, 3'b010, 32'hA2, 3'b010, 0, 4'h1);
    checkSeq("lock.config", 3'd3, 3'b100, 2'd1);
    beatCycle("lock.b3stall", 32'hA3, 1, 0, 0, 3'b000, 32'hA3, 3'b000, 0, 4'h1);
    beatCycle("lock.b3", 32'hA3, 1, 0, 1, 3'b000, 32'hA3, 3'b010, 0, 4'h1);
    beatCycle("lock.b4", 32'hA4, 1, 1, 1, 3'b000, 32'hA4, 3'b010, 1, 4'h1);
    beatCycle("lock.cfg", 32'h0, 0, 0, 1, 3'b000, 32'hC000_0001, 3'b100, 1, 4'h2);

    // Reset in CONFIG with a config packet open
    s_tdata[95:64] = 32'hC000_0002;
    s_tlast[2]     = 1'b0;
    beatCycle("rst.cfg_open", 32'h0, 0, 0, 1, 3'b000, 32'hC000_0002, 3'b100, 0, 4'h2);
    rst = 1'b1;
    tick();
    checkSeq("rst.mid", 3'd0, 3'b000, 2'd0);
    checkOutput("rst.link_up", 32'(link_up), 32'd0);
    checkOutput("rst.tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst.tready", 32'(s_tready), 32'd0);
    rst = 1'b0;
    s_tdata[31:0] = 32'hD000_0000;
    s_tvalid[0]   = 1'b1;
    applyStimulus(1, 3'b000, 3'b000);
    checkOutput("rst.unlock_data", m_tdata, 32'hD000_0000);
    checkOutput("rst.unlock_ready", 32'(s_tready), 32'(3'b001));
    s_tvalid = 3'b000;
    applyStimulus(0, 3'b000, 3'b000);

    // Timeout on the 16-cycle instance
    to_link_en = 1'b1;
    tick();
    checkOutput("to.detect", 32'(to_state), 32'd1);
    checkOutput("to.sub_en", 32'(to_sub_en), 32'(3'b001));
    repeat (15) tick();
    checkOutput("to.still_detect", 32'(to_state), 32'd1);
    tick();
    checkOutput("to.restart", 32'(to_state), 32'd5);
    checkOutput("to.retry", 32'(to_retry), 32'd1);
    checkOutput("to.sub_en_low", 32'(to_sub_en), 32'd0);
    tick();
    checkOutput("to.redetect", 32'(to_state), 32'd1);
    to_link_en = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
